// File: rtl/packetiser_multi.sv
// Snapshots N_CH (value,count) pairs on trigger and streams them as one AXIS packet; tvalid 1 cycle after trigger.
// Back-pressure: tdata/tlast/tvalid frozen while tvalid && !tready; triggers landing mid-packet only bump overrun_cnt.
module packetiser_multi #(
  parameter int N_CH   = 4,
  parameter int VAL_W  = 64,
  parameter int HDR_EN = 1
) (
  input  logic                    aclk,
  input  logic                    rst,
  input  logic [N_CH*VAL_W-1:0]   val_in,
  input  logic [N_CH*32-1:0]      cnt_in,
  input  logic                    trigger,
  output logic [31:0]             M_AXIS_OUT_tdata,
  output logic                    M_AXIS_OUT_tvalid,
  input  logic                    M_AXIS_OUT_tready,
  output logic                    M_AXIS_OUT_tlast,
  output logic                    busy,
  output logic [15:0]             seq_num,
  output logic [15:0]             overrun_cnt
);

  localparam int VPC    = VAL_W / 32;
  localparam int WPC    = VPC + 1;
  localparam int NW     = HDR_EN + N_CH * WPC;
  localparam int IDX_W  = $clog2(NW + 1);
  localparam int CH_W   = $clog2(N_CH + 1);
  localparam int SLOT_W = $clog2(WPC + 1);

  typedef enum logic [0:0] {S_IDLE, S_SEND} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [N_CH*VAL_W-1:0]   r_val;
  logic [N_CH*32-1:0]      r_cnt;
  logic [15:0]             r_seq;
  logic [15:0]             r_ovr;
  logic [IDX_W-1:0]        r_idx;
  logic [CH_W-1:0]         r_ch;
  logic [SLOT_W-1:0]       r_slot;
  logic                    r_hdr;
  logic [31:0]             r_tdata;
  logic                    r_tlast;

  logic                    w_beat;
  logic                    w_accept;
  logic                    w_advance;
  logic                    w_finish;
  logic                    w_overrun;
  logic [CH_W-1:0]         w_nch;
  logic [SLOT_W-1:0]       w_nslot;
  logic [31:0]             w_next_word;

  always_ff @(posedge aclk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat      = 1'b0;
    w_accept    = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (trigger) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_beat = M_AXIS_OUT_tready;
        // A trigger on the final beat chains the next packet with no idle gap.
        if (w_beat && r_tlast) begin
          if (trigger) begin
            w_accept = 1'b1;
          end else begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_advance = w_beat;
          w_overrun = trigger;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Position and contents of the word that follows the one currently presented.
  always_comb begin
    w_nch       = r_ch;
    w_nslot     = r_slot;
    w_next_word = '0;
    if (r_hdr) begin
      w_nch   = '0;
      w_nslot = '0;
    end else if (r_slot == SLOT_W'(VPC)) begin
      w_nch   = r_ch + CH_W'(1);
      w_nslot = '0;
    end else begin
      w_nslot = r_slot + SLOT_W'(1);
    end
    if (int'(w_nch) < N_CH) begin
      if (w_nslot == SLOT_W'(VPC))
        w_next_word = r_cnt[32*int'(w_nch) +: 32];
      else
        w_next_word = r_val[VAL_W*int'(w_nch) + 32*int'(w_nslot) +: 32];
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_val   <= '0;
      r_cnt   <= '0;
      r_seq   <= '0;
      r_ovr   <= '0;
      r_idx   <= '0;
      r_ch    <= '0;
      r_slot  <= '0;
      r_hdr   <= 1'b0;
      r_tdata <= '0;
      r_tlast <= 1'b0;
    end else begin
      if (w_accept) begin
        r_val   <= val_in;
        r_cnt   <= cnt_in;
        r_seq   <= r_seq + 16'd1;
        r_idx   <= '0;
        r_ch    <= '0;
        r_slot  <= '0;
        r_hdr   <= (HDR_EN != 0);
        r_tlast <= 1'b0;
        if (HDR_EN != 0) r_tdata <= {8'hA5, 8'(N_CH), r_seq + 16'd1};
        else             r_tdata <= val_in[31:0];
      end else if (w_advance) begin
        r_idx   <= r_idx + IDX_W'(1);
        r_ch    <= w_nch;
        r_slot  <= w_nslot;
        r_hdr   <= 1'b0;
        r_tdata <= w_next_word;
        r_tlast <= ((r_idx + IDX_W'(1)) == IDX_W'(NW - 1));
      end else if (w_finish) begin
        r_tdata <= '0;
        r_tlast <= 1'b0;
      end
      if (w_overrun && (r_ovr != 16'hFFFF)) r_ovr <= r_ovr + 16'd1;
    end
  end

  assign M_AXIS_OUT_tdata  = r_tdata;
  assign M_AXIS_OUT_tlast  = r_tlast;
  assign M_AXIS_OUT_tvalid = (r_state == S_SEND);
  assign busy              = (r_state == S_SEND);
  assign seq_num           = r_seq;
  assign overrun_cnt       = r_ovr;

endmodule

// File: tb/tb_packetiser_multi.sv
// Bench for packetiser_multi: default-parameter instance against a packet-queue model, plus a
// single-channel headerless instance driven from a cycle table.
module tb_packetiser_multi;
  localparam int NCH = 4;
  localparam int VW  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NCH*VW-1:0]   val_a;
  logic [NCH*32-1:0]   cnt_a;
  logic                trig_a, rdy_a, vld_a, last_a, busy_a;
  logic [31:0]         dat_a;
  logic [15:0]         seq_a, ovr_a;

  logic [127:0]        val_b;
  logic [31:0]         cnt_b;
  logic                trig_b, rdy_b, vld_b, last_b, busy_b;
  logic [31:0]         dat_b;
  logic [15:0]         seq_b, ovr_b;

  packetiser_multi #(.N_CH(NCH), .VAL_W(VW), .HDR_EN(1)) dut_a (
    .aclk(clk), .rst(rst), .val_in(val_a), .cnt_in(cnt_a), .trigger(trig_a),
    .M_AXIS_OUT_tdata(dat_a), .M_AXIS_OUT_tvalid(vld_a), .M_AXIS_OUT_tready(rdy_a),
    .M_AXIS_OUT_tlast(last_a), .busy(busy_a), .seq_num(seq_a), .overrun_cnt(ovr_a));

  packetiser_multi #(.N_CH(1), .VAL_W(128), .HDR_EN(0)) dut_b (
    .aclk(clk), .rst(rst), .val_in(val_b), .cnt_in(cnt_b), .trigger(trig_b),
    .M_AXIS_OUT_tdata(dat_b), .M_AXIS_OUT_tvalid(vld_b), .M_AXIS_OUT_tready(rdy_b),
    .M_AXIS_OUT_tlast(last_b), .busy(busy_b), .seq_num(seq_b), .overrun_cnt(ovr_b));

  typedef struct {logic [31:0] dat; logic last;} word_t;
  typedef struct {bit trig; bit rdy; bit exp_vld; logic [31:0] exp_dat; bit exp_last;} vec_t;

  word_t       mq[$];
  word_t       log_q[$];
  logic [15:0] m_seq, m_ovr;
  int          n_tests = 0, n_fail = 0;
  int          b_row = -1;
  vec_t        tbl[9];
  logic [31:0] exp1[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push_packet(input logic [15:0] seq, input logic [NCH*VW-1:0] v,
                             input logic [NCH*32-1:0] c);
    word_t w;
    w.dat = {8'hA5, 8'(NCH), seq};
    w.last = 1'b0;
    mq.push_back(w);
    for (int ch = 0; ch < NCH; ch++) begin
      for (int s = 0; s < VW/32; s++) begin
        w.dat = v[ch*VW + s*32 +: 32];
        w.last = 1'b0;
        mq.push_back(w);
      end
      w.dat = c[ch*32 +: 32];
      w.last = (ch == NCH-1);
      mq.push_back(w);
    end
  endtask

  task automatic model_step();
    bit    exp_vld, beat, fin;
    word_t w;
    exp_vld = (mq.size() > 0);
    chk("a_tvalid", 32'(vld_a), 32'(exp_vld));
    chk("a_busy", 32'(busy_a), 32'(exp_vld));
    chk("a_seq_num", 32'(seq_a), 32'(m_seq));
    chk("a_overrun_cnt", 32'(ovr_a), 32'(m_ovr));
    if (exp_vld) begin
      chk("a_tdata", dat_a, mq[0].dat);
      chk("a_tlast", 32'(last_a), 32'(mq[0].last));
    end else begin
      chk("a_tlast_idle", 32'(last_a), 32'd0);
    end
    if (rst) begin
      mq.delete();
      m_seq = '0;
      m_ovr = '0;
    end else begin
      if (vld_a && rdy_a) begin
        w.dat = dat_a;
        w.last = last_a;
        log_q.push_back(w);
      end
      beat = exp_vld && rdy_a;
      fin  = beat && mq[0].last;
      if (beat) void'(mq.pop_front());
      if (trig_a) begin
        if (!exp_vld || fin) begin
          m_seq = m_seq + 16'd1;
          push_packet(m_seq, val_a, cnt_a);
        end else if (m_ovr != 16'hFFFF) begin
          m_ovr = m_ovr + 16'd1;
        end
      end
    end
  endtask

  task automatic check_b(input int i);
    chk($sformatf("b_tvalid[%0d]", i), 32'(vld_b), 32'(tbl[i].exp_vld));
    if (tbl[i].exp_vld) begin
      chk($sformatf("b_tdata[%0d]", i), dat_b, tbl[i].exp_dat);
      chk($sformatf("b_tlast[%0d]", i), 32'(last_b), 32'(tbl[i].exp_last));
    end else begin
      chk($sformatf("b_tlast[%0d]", i), 32'(last_b), 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    if (b_row >= 0) check_b(b_row);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_log(input string name, input logic [31:0] hdr);
    chk({name, "_beats"}, 32'(log_q.size()), 32'd13);
    for (int i = 0; i < 13; i++) begin
      if (i < log_q.size()) begin
        chk($sformatf("%s_word%0d", name, i), log_q[i].dat, (i == 0) ? hdr : exp1[i]);
        chk($sformatf("%s_last%0d", name, i), 32'(log_q[i].last), 32'(i == 12));
      end
    end
  endtask

  task automatic rand_vals();
    for (int i = 0; i < NCH*VW/32; i++) val_a[i*32 +: 32] = $urandom;
    for (int i = 0; i < NCH; i++) cnt_a[i*32 +: 32] = $urandom;
  endtask

  initial begin
    int gap;
    //          trig rdy vld  dat    last
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'd0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 32'd1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'd1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'd2, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'd3, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'd3, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'd4, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'd9, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 32'd0, 1'b0};
    exp1 = '{32'hA504_0001,
             32'h0000_0000, 32'h1111_0000, 32'h0000_000A,
             32'h0000_0001, 32'h1111_0000, 32'h0000_000B,
             32'h0000_0002, 32'h1111_0000, 32'h0000_000C,
             32'h0000_0003, 32'h1111_0000, 32'h0000_000D};

    rst = 1'b1; trig_a = 1'b0; rdy_a = 1'b1; val_a = '0; cnt_a = '0;
    trig_b = 1'b0; rdy_b = 1'b1; val_b = '0; cnt_b = '0;
    m_seq = '0; m_ovr = '0;
    @(posedge clk); #1;
    tick();
    chk("reset_tdata", dat_a, 32'd0);
    rst = 1'b0;

    // Single packet, tready held high
    for (int k = 0; k < NCH; k++) begin
      val_a[k*VW +: VW] = 64'h1111_0000_0000_0000 | 64'(k);
      cnt_a[k*32 +: 32] = 32'(k + 10);
    end
    log_q.delete();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    repeat (16) tick();
    check_log("pkt1", 32'hA504_0001);

    // Back-pressure pattern 1,0,0,1
    log_q.delete();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    for (int c = 0; c < 60; c++) begin
      rdy_a = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    rdy_a = 1'b1;
    repeat (4) tick();
    check_log("bp", 32'hA504_0002);

    // Mid-packet triggers dropped, then overrun saturation
    reset_pulse();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      trig_a = (c == 3) || (c == 7);
      tick();
    end
    trig_a = 1'b0;
    chk("ovr_two", 32'(ovr_a), 32'd2);
    chk("seq_one", 32'(seq_a), 32'd1);
    rdy_a = 1'b0;
    trig_a = 1'b1; tick();
    repeat (65540) tick();
    trig_a = 1'b0;
    chk("ovr_sat", 32'(ovr_a), 32'h0000_FFFF);
    rdy_a = 1'b1;
    repeat (16) tick();

    // Trigger on the final beat chains two packets
    reset_pulse();
    log_q.delete();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (vld_a && last_a) break;
      tick();
    end
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    gap = 0;
    for (int c = 0; c < 40; c++) begin
      if (log_q.size() >= 26) break;
      if (!vld_a) gap++;
      tick();
    end
    chk("b2b_beats", 32'(log_q.size()), 32'd26);
    chk("b2b_gap", 32'(gap), 32'd0);
    if (log_q.size() >= 26) begin
      chk("b2b_last13", 32'(log_q[12].last), 32'd1);
      chk("b2b_hdr2", log_q[13].dat, 32'hA504_0002);
      chk("b2b_last26", 32'(log_q[25].last), 32'd1);
    end
    repeat (3) tick();

    // Reset in the middle of a packet
    log_q.delete();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (log_q.size() >= 4) break;
      tick();
    end
    reset_pulse();
    chk("rst_tvalid", 32'(vld_a), 32'd0);
    chk("rst_tlast", 32'(last_a), 32'd0);
    chk("rst_tdata", dat_a, 32'd0);
    chk("rst_seq", 32'(seq_a), 32'd0);
    chk("rst_ovr", 32'(ovr_a), 32'd0);
    log_q.delete();
    trig_a = 1'b1; tick(); trig_a = 1'b0;
    repeat (16) tick();
    chk("post_rst_beats", 32'(log_q.size()), 32'd13);
    if (log_q.size() >= 13) begin
      chk("post_rst_hdr", log_q[0].dat, 32'hA504_0001);
      chk("post_rst_last", 32'(log_q[12].last), 32'd1);
    end

    // Single-channel, headerless, 128-bit value instance
    val_b = {32'd4, 32'd3, 32'd2, 32'd1};
    cnt_b = 32'd9;
    for (int i = 0; i < 9; i++) begin
      trig_b = tbl[i].trig;
      rdy_b  = tbl[i].rdy;
      if (i > 0) begin
        val_b = {$urandom, $urandom, $urandom, $urandom};
        cnt_b = $urandom;
      end
      b_row = i;
      tick();
    end
    b_row = -1;
    trig_b = 1'b0;
    chk("b_overrun", 32'(ovr_b), 32'd1);
    chk("b_seq", 32'(seq_b), 32'd1);

    // Randomised traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rand_vals();
      rdy_a  = ($urandom_range(0, 9) < 7);
      trig_a = ($urandom_range(0, 7) == 0);
      rst    = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; trig_a = 1'b0; rdy_a = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
